// File: rtl/memtest_elapsed_bcd.sv
// memtest_elapsed_bcd
//
// Elapsed-time and fail-timestamp unit for memory-test tops. The clock is
// prescaled down to one tick per elapsed unit. An N-digit BCD counter keeps
// the elapsed time. The elapsed value present at the first synchronised test
// failure is latched. This block lives in the GUI/pixel clock domain.
// fail_any may come from another domain, so it is resynchronised here.
//
// Parameters:
//   CLK_HZ       clk frequency in Hz
//   UNIT_S       seconds per elapsed unit (1 = seconds, 60 = minutes)
//   DIGITS       BCD digits in elapsed/first_fail (1..8)
//   SATURATE     0: all-9s wraps to 0 with an overflow pulse; 1: holds at all-9s
//   STOP_ON_FAIL 1: counting halts when the first fail is latched
//   SYNC_STAGES  flops on the fail_any synchroniser (>= 2)
//   CLK_HZ * UNIT_S must be at least 2.
//
// Ports:
//   clk         unit clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear of prescaler, counters, flags and state
//   run         counting enable (level)
//   fail_any    asynchronous fail level, 1 = failcount nonzero
//   tick        one-cycle pulse per elapsed unit
//   elapsed     BCD elapsed units, digit 0 in [3:0]
//   first_fail  elapsed value captured at the first synchronised fail
//   fail_seen   sticky, first_fail valid
//   overflow    wrap pulse (SATURATE=0) or sticky saturation flag (SATURATE=1)
//   mark        one-hot marker, 8'h80 after reset, rotates right per tick
//   state       00 STOPPED, 01 RUNNING, 10 HALTED, 11 SATURATED
module memtest_elapsed_bcd #(
    parameter int unsigned CLK_HZ       = 27500000,
    parameter int unsigned UNIT_S       = 60,
    parameter int unsigned DIGITS       = 4,
    parameter bit          SATURATE     = 1'b0,
    parameter bit          STOP_ON_FAIL = 1'b0,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  run,
    input  logic                  fail_any,
    output logic                  tick,
    output logic [4*DIGITS-1:0]   elapsed,
    output logic [4*DIGITS-1:0]   first_fail,
    output logic                  fail_seen,
    output logic                  overflow,
    output logic [7:0]            mark,
    output logic [1:0]            state
);

    localparam logic [63:0]   PRESCALE  = 64'(CLK_HZ) * 64'(UNIT_S);
    localparam int unsigned   PW        = (PRESCALE > 64'd1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 64'd1);
    localparam int unsigned   EW        = 4 * DIGITS;

    typedef enum logic [1:0] {
        StStopped   = 2'b00,
        StRunning   = 2'b01,
        StHalted    = 2'b10,
        StSaturated = 2'b11
    } state_e;

    state_e                 state_q;
    logic [PW-1:0]          presc_q;
    logic                   tick_q;
    logic [EW-1:0]          elapsed_q;
    logic [EW-1:0]          first_fail_q;
    logic                   fail_seen_q;
    logic                   overflow_q;
    logic [7:0]             mark_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fail_prev_q;

    // fail_any synchroniser. clr deliberately leaves it and fail_prev_q alone.
    // A fail held high through clr then cannot re-latch until it falls and
    // rises again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fail_any};
        end
    end

    logic fail_sync;
    logic fail_latch;
    assign fail_sync  = sync_q[SYNC_STAGES-1];
    assign fail_latch = fail_sync & ~fail_prev_q & ~fail_seen_q;

    // BCD increment with ripple carry. An all-9s value rolls to all-0s.
    logic [EW-1:0] elapsed_inc;
    logic          all_nines;
    logic          carry;
    always_comb begin
        elapsed_inc = elapsed_q;
        all_nines   = 1'b1;
        carry       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (elapsed_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (elapsed_q[4*i +: 4] >= 4'd9) begin
                    elapsed_inc[4*i +: 4] = 4'd0;
                end else begin
                    elapsed_inc[4*i +: 4] = elapsed_q[4*i +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    logic running;
    logic halt_now;
    logic count_en;
    logic at_max;
    logic sat_now;
    assign running  = (state_q == StRunning) && run;
    // The halting cycle does not count, so elapsed stays equal to first_fail.
    assign halt_now = running && STOP_ON_FAIL && fail_latch;
    assign count_en = running && !halt_now;
    assign at_max   = (presc_q == PRESC_MAX);
    assign sat_now  = count_en && at_max && all_nines && SATURATE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StStopped;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            elapsed_q    <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            overflow_q   <= 1'b0;
            mark_q       <= 8'h80;
            fail_prev_q  <= 1'b0;
        end else begin
            fail_prev_q <= fail_sync;
            tick_q      <= 1'b0;
            if (!SATURATE) begin
                overflow_q <= 1'b0;
            end

            if (clr) begin
                state_q      <= StStopped;
                presc_q      <= '0;
                elapsed_q    <= '0;
                first_fail_q <= '0;
                fail_seen_q  <= 1'b0;
                overflow_q   <= 1'b0;
                mark_q       <= 8'h80;
            end else begin
                // Capture the value present this cycle (pre-increment on a tick).
                if (fail_latch) begin
                    first_fail_q <= elapsed_q;
                    fail_seen_q  <= 1'b1;
                end

                if (count_en) begin
                    if (at_max) begin
                        presc_q <= '0;
                        if (sat_now) begin
                            overflow_q <= 1'b1;
                        end else begin
                            tick_q    <= 1'b1;
                            elapsed_q <= elapsed_inc;
                            mark_q    <= {mark_q[0], mark_q[7:1]};
                            if (all_nines) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end

                case (state_q)
                    StStopped: begin
                        if (run) begin
                            state_q <= StRunning;
                        end
                    end
                    StRunning: begin
                        if (!run) begin
                            state_q <= StStopped;
                        end else if (halt_now) begin
                            state_q <= StHalted;
                        end else if (sat_now) begin
                            state_q <= StSaturated;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign tick       = tick_q;
    assign elapsed    = elapsed_q;
    assign first_fail = first_fail_q;
    assign fail_seen  = fail_seen_q;
    assign overflow   = overflow_q;
    assign mark       = mark_q;
    assign state      = state_q;

endmodule
